stage_output_mixer: RTL and testbench
=====================================

Name: stage_output_mixer

Overview:
Final synthesis pipeline stage, directly downstream of the envelope attenuator stage. Consumes one attenuated operator sample per clock, tagged with its voice-operator ID and algorithm word. Sums the carrier-operator samples of one full voice-operator sweep into a mixed audio sample. Emits a saturated 16-bit sample with a one-cycle ready strobe per sweep, for the DAC/I2S serializer.

Parameters:
NUM_OPS, `NUM_VOICE_OPERATORS, number of voice-operator slots per sweep; IDs run 0..NUM_OPS-1.
CARRIER_BIT, 0, index of the AlgorithmWord_t bit that marks the operator as a carrier (1 = summed into output).
ACC_WIDTH, 24, signed accumulator width; must be >= 16 + clog2(NUM_OPS).
OUTPUT_SHIFT, 5, arithmetic right shift applied to the accumulator before output saturation.

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous active-high reset
i_VoiceOperator  in  VoiceOperatorID_t  ID of the sample on i_Waveform
i_AlgorithmWord  in  AlgorithmWord_t  algorithm word of that operator
i_Waveform  in  16 signed  attenuated operator sample
o_Sample  out  16 signed  mixed output sample, held between strobes
o_SampleReady  out  1  one-cycle strobe; o_Sample updated this cycle
o_SequenceError  out  1  sticky flag; ID sequence broken since reset

Behaviour:
- Reset is synchronous and active-high. While i_Reset = 1 at a clock edge:
  - o_Sample = 0, o_SampleReady = 0, o_SequenceError = 0.
  - Accumulator = 0, FrameValid = 0.
  - All pipeline registers are cleared; the captured ID is set to NUM_OPS-1 so the next expected ID is 0.
- Stage 1 (clock 1): register i_VoiceOperator, the carrier bit i_AlgorithmWord[CARRIER_BIT], and i_Waveform.
- Stage 2 (clock 2), accumulate:
  - term = carrier ? sign-extend(waveform) to ACC_WIDTH : 0.
  - If the registered ID == 0: acc <= term (new sweep) and FrameValid <= 1.
  - Otherwise: acc <= sat_ACC(acc + term), clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; no wrap.
  - Registered ID == NUM_OPS-1 marks the last slot; set flag LastSlot for stage 3.
- Stage 3 (clock 3), output:
  - If LastSlot and FrameValid: o_Sample <= sat16(acc >>> OUTPUT_SHIFT), clamped to [-32768, 32767]; o_SampleReady <= 1.
  - Otherwise o_SampleReady <= 0 and o_Sample holds its value.
- Latency: the sample with ID NUM_OPS-1 presented at input edge t produces o_SampleReady = 1 in the cycle after edge t+3 (3 register stages).
- Sequence check:
  - Expected ID = (previous registered ID + 1) mod NUM_OPS.
  - A mismatch in stage 2 sets o_SequenceError = 1 (sticky until reset) and clears FrameValid.
  - A cleared FrameValid suppresses the next strobe; the following ID 0 re-arms it.
- First sweep after reset: no strobe until a sweep has started at ID 0. A partial sweep whose first ID is nonzero is discarded, with no error flagged for that first out-of-sequence entry.
- Non-carrier samples contribute 0 but still advance the sequence check.
- Reset mid-sweep: the partial sum is discarded and no strobe is issued for it.

Optional Feature:
MIXER_DC_BLOCK_EN
- Defined: insert a stage 4 one-pole DC blocker on each strobed sample.
  - y = sat16(x - x_prev + y_prev - (y_prev >>> 8)), with x_prev and y_prev updated only on strobes and reset to 0.
  - Adds one cycle of latency; o_SampleReady is delayed to match.
- Undefined: stage 4 is absent; o_Sample is sat16(acc >>> OUTPUT_SHIFT) with 3-cycle latency.

Test Plan:
1. Reset, then one sweep with NUM_OPS=8, SHIFT=0, all carriers, each sample 100 -> o_SampleReady pulses once, o_Sample = 800, latency 3 cycles after ID 7.
2. Carrier bit set only on IDs 2 and 5, samples 1000 and -300, others 5000 -> o_Sample = 700 (SHIFT=0).
3. All carriers at 32767, NUM_OPS=32, SHIFT=0 -> o_Sample saturates to 32767; with SHIFT=5 -> o_Sample = 32767 (sum 1048544 >>> 5 = 32767).
4. Sweep with ID 4 skipped (3 then 5) -> o_SequenceError = 1 and stays 1; no strobe for that sweep; the next clean sweep strobes normally.
5. Start input at ID 3 after reset, then full sweeps -> no strobe and no error for the partial sweep; the first strobe follows the first complete 0..NUM_OPS-1 sweep.
6. Assert i_Reset at ID 4 mid-sweep -> outputs are 0 the next cycle; no strobe for the partial sum. With MIXER_DC_BLOCK_EN, a constant 1000 input decays toward 0 across strobes and the first strobe reads 1000.

Source files
------------

// File: rtl/stage_output_mixer.sv
// Output mixer: sums the carrier-operator samples of one voice-operator sweep into a saturated
// 16-bit sample with a one-cycle ready strobe. Define MIXER_DC_BLOCK_EN to add a DC-blocker stage.

`ifndef NUM_VOICE_OPERATORS
`define NUM_VOICE_OPERATORS 32
`endif

module stage_output_mixer #(
    parameter int unsigned NUM_OPS      = `NUM_VOICE_OPERATORS,
    parameter int unsigned CARRIER_BIT  = 0,
    parameter int unsigned ACC_WIDTH    = 24,
    parameter int unsigned OUTPUT_SHIFT = 5,
    parameter int unsigned ALG_WIDTH    = 8,
    parameter int unsigned ID_WIDTH     = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [ID_WIDTH-1:0]   i_VoiceOperator,
    input  logic [ALG_WIDTH-1:0]  i_AlgorithmWord,
    input  logic signed [15:0]    i_Waveform,
    output logic signed [15:0]    o_Sample,
    output logic                  o_SampleReady,
    output logic                  o_SequenceError
);

    localparam logic [ID_WIDTH-1:0] LastId = ID_WIDTH'(NUM_OPS - 1);

    logic                        s1_valid_q, s1_valid_d;
    logic [ID_WIDTH-1:0]         s1_id_q, s1_id_d;
    logic                        s1_carrier_q, s1_carrier_d;
    logic signed [15:0]          s1_wave_q, s1_wave_d;
    logic [ID_WIDTH-1:0]         prev_id_q, prev_id_d;
    logic                        first_q, first_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        last_q, last_d;
    logic                        err_q, err_d;
    logic signed [15:0]          out_sample_q, out_sample_d;
    logic                        out_ready_q, out_ready_d;

    logic signed [ACC_WIDTH-1:0] term;
    logic signed [ACC_WIDTH:0]   sum_wide;
    logic signed [ACC_WIDTH-1:0] sum_sat;
    logic signed [ACC_WIDTH-1:0] acc_shifted;
    logic [ID_WIDTH-1:0]         expected_id;
    logic                        seq_mismatch;
    logic                        unused_alg;

    assign unused_alg = ^i_AlgorithmWord;

    always_comb begin
        s1_valid_d   = 1'b1;
        s1_id_d      = i_VoiceOperator;
        s1_carrier_d = i_AlgorithmWord[CARRIER_BIT];
        s1_wave_d    = i_Waveform;
    end

    always_comb begin
        term = s1_carrier_q ? {{(ACC_WIDTH-16){s1_wave_q[15]}}, s1_wave_q} : '0;
        sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {term[ACC_WIDTH-1], term};
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sum_sat = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            sum_sat = sum_wide[ACC_WIDTH-1:0];
        end
        expected_id  = (prev_id_q == LastId) ? '0 : prev_id_q + 1'b1;
        // The very first entry after reset has no predecessor, so it is never an error.
        seq_mismatch = s1_valid_q && !first_q && (s1_id_q != expected_id);

        prev_id_d     = prev_id_q;
        first_d       = first_q;
        acc_d         = acc_q;
        frame_valid_d = frame_valid_q;
        last_d        = 1'b0;
        err_d         = err_q || seq_mismatch;
        if (s1_valid_q) begin
            if (seq_mismatch) frame_valid_d = 1'b0;
            // ID 0 always opens a fresh sweep, even when it arrives out of order.
            if (s1_id_q == '0) begin
                acc_d         = term;
                frame_valid_d = 1'b1;
            end else begin
                acc_d = sum_sat;
            end
            last_d    = (s1_id_q == LastId);
            prev_id_d = s1_id_q;
            first_d   = 1'b0;
        end
    end

    always_comb begin
        acc_shifted  = acc_q >>> OUTPUT_SHIFT;
        out_ready_d  = last_q && frame_valid_q;
        out_sample_d = out_sample_q;
        if (out_ready_d) begin
            if (&acc_shifted[ACC_WIDTH-1:15] || ~|acc_shifted[ACC_WIDTH-1:15]) begin
                out_sample_d = acc_shifted[15:0];
            end else begin
                out_sample_d = acc_shifted[ACC_WIDTH-1] ? 16'sh8000 : 16'sh7fff;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1_valid_q    <= 1'b0;
            s1_id_q       <= LastId;
            s1_carrier_q  <= 1'b0;
            s1_wave_q     <= '0;
            prev_id_q     <= LastId;
            first_q       <= 1'b1;
            acc_q         <= '0;
            frame_valid_q <= 1'b0;
            last_q        <= 1'b0;
            err_q         <= 1'b0;
            out_sample_q  <= '0;
            out_ready_q   <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_id_q       <= s1_id_d;
            s1_carrier_q  <= s1_carrier_d;
            s1_wave_q     <= s1_wave_d;
            prev_id_q     <= prev_id_d;
            first_q       <= first_d;
            acc_q         <= acc_d;
            frame_valid_q <= frame_valid_d;
            last_q        <= last_d;
            err_q         <= err_d;
            out_sample_q  <= out_sample_d;
            out_ready_q   <= out_ready_d;
        end
    end

    assign o_SequenceError = err_q;

`ifdef MIXER_DC_BLOCK_EN
    logic signed [15:0] x_prev_q, x_prev_d;
    logic signed [15:0] y_prev_q, y_prev_d;
    logic signed [15:0] dc_sample_q, dc_sample_d;
    logic               dc_ready_q, dc_ready_d;
    logic signed [15:0] y_decay;
    logic signed [19:0] dc_wide;
    logic signed [15:0] dc_y;

    // One-pole high-pass: y = x - x_prev + y_prev - y_prev/256, advanced only on strobes.
    always_comb begin
        y_decay = y_prev_q >>> 8;
        dc_wide = {{4{out_sample_q[15]}}, out_sample_q} - {{4{x_prev_q[15]}}, x_prev_q}
                + {{4{y_prev_q[15]}}, y_prev_q} - {{4{y_decay[15]}}, y_decay};
        if (&dc_wide[19:15] || ~|dc_wide[19:15]) begin
            dc_y = dc_wide[15:0];
        end else begin
            dc_y = dc_wide[19] ? 16'sh8000 : 16'sh7fff;
        end
        dc_ready_d  = out_ready_q;
        dc_sample_d = dc_sample_q;
        x_prev_d    = x_prev_q;
        y_prev_d    = y_prev_q;
        if (out_ready_q) begin
            dc_sample_d = dc_y;
            x_prev_d    = out_sample_q;
            y_prev_d    = dc_y;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            x_prev_q    <= '0;
            y_prev_q    <= '0;
            dc_sample_q <= '0;
            dc_ready_q  <= 1'b0;
        end else begin
            x_prev_q    <= x_prev_d;
            y_prev_q    <= y_prev_d;
            dc_sample_q <= dc_sample_d;
            dc_ready_q  <= dc_ready_d;
        end
    end

    assign o_Sample      = dc_sample_q;
    assign o_SampleReady = dc_ready_q;
`else
    assign o_Sample      = out_sample_q;
    assign o_SampleReady = out_ready_q;
`endif

endmodule

// File: tb/tb_stage_output_mixer.sv
// Bench for stage_output_mixer: directed sweeps with literal expectations, then random stimulus
// checked every cycle against a sweep-level behavioural model of two shift configurations.

module tb_stage_output_mixer;

    localparam int NOPS = 8;
    localparam int CBIT = 2;
    localparam int ACCW = 24;

    logic               clk;
    logic               rst;
    logic [2:0]         vid;
    logic [7:0]         alg;
    logic signed [15:0] wave;
    logic signed [15:0] s0, s1;
    logic               r0, r1, e0, e1;

    int n_checks = 0;
    int n_err    = 0;

    stage_output_mixer #(
        .NUM_OPS(NOPS), .CARRIER_BIT(CBIT), .ACC_WIDTH(ACCW), .OUTPUT_SHIFT(0), .ALG_WIDTH(8)
    ) u_dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_VoiceOperator(vid), .i_AlgorithmWord(alg),
        .i_Waveform(wave), .o_Sample(s0), .o_SampleReady(r0), .o_SequenceError(e0)
    );

    stage_output_mixer #(
        .NUM_OPS(NOPS), .CARRIER_BIT(CBIT), .ACC_WIDTH(ACCW), .OUTPUT_SHIFT(2), .ALG_WIDTH(8)
    ) u_dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_VoiceOperator(vid), .i_AlgorithmWord(alg),
        .i_Waveform(wave), .o_Sample(s1), .o_SampleReady(r1), .o_SequenceError(e1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic longint sat_acc(input longint v);
        longint lim;
        lim = longint'(1) <<< (ACCW - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Behavioural model: one entry per captured input, sweep-level bookkeeping.
    bit     model_ok = 0;
    bit     cap_valid;
    int     cap_id, cap_w;
    bit     cap_car;
    int     prev_id;
    bit     m_first, armed;
    longint sum;
    bit     pend_strobe;
    int     pend_val[2];
    bit     dc_strobe;
    int     dc_val[2], xp[2], yp[2];
    int     exp_sample[2];
    bit     exp_ready, exp_err;
    int     shift_of[2] = '{0, 2};

    task automatic model_step();
        longint term;
        if (rst) begin
            model_ok = 1; prev_id = NOPS - 1; m_first = 1; armed = 0; sum = 0;
            pend_strobe = 0; dc_strobe = 0; exp_ready = 0; exp_err = 0;
            for (int k = 0; k < 2; k++) begin
                exp_sample[k] = 0; xp[k] = 0; yp[k] = 0; dc_val[k] = 0; pend_val[k] = 0;
            end
        end else begin
`ifdef MIXER_DC_BLOCK_EN
            exp_ready = dc_strobe;
            if (dc_strobe) for (int k = 0; k < 2; k++) exp_sample[k] = dc_val[k];
            dc_strobe = pend_strobe;
            if (pend_strobe) begin
                for (int k = 0; k < 2; k++) begin
                    dc_val[k] = sat16(longint'(pend_val[k] - xp[k] + yp[k] - (yp[k] >>> 8)));
                    xp[k] = pend_val[k];
                    yp[k] = dc_val[k];
                end
            end
`else
            exp_ready = pend_strobe;
            if (pend_strobe) for (int k = 0; k < 2; k++) exp_sample[k] = pend_val[k];
`endif
            pend_strobe = 0;
            if (cap_valid) begin
                term = cap_car ? longint'(cap_w) : 0;
                if (!m_first && cap_id != (prev_id + 1) % NOPS) begin
                    exp_err = 1;
                    armed = 0;
                end
                m_first = 0;
                if (cap_id == 0) begin
                    sum = term;
                    armed = 1;
                end else begin
                    sum = sat_acc(sum + term);
                end
                prev_id = cap_id;
                if (cap_id == NOPS - 1 && armed) begin
                    pend_strobe = 1;
                    for (int k = 0; k < 2; k++) pend_val[k] = sat16(sum >>> shift_of[k]);
                end
            end
        end
        cap_valid = !rst;
        cap_id    = int'(vid);
        cap_car   = alg[CBIT];
        cap_w     = int'(wave);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            check("ready0", int'(r0), int'(exp_ready));
            check("sample0", int'(s0), exp_sample[0]);
            check("seqerr0", int'(e0), int'(exp_err));
            check("ready1", int'(r1), int'(exp_ready));
            check("sample1", int'(s1), exp_sample[1]);
            check("seqerr1", int'(e1), int'(exp_err));
        end
    end

    task automatic drive(input int id, input bit car, input int w);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        vid  = 3'(id);
        alg  = 8'($urandom);
        alg[CBIT] = car;
        wave = 16'(w);
    endtask

    task automatic reset_at(input int id);
        @(posedge clk);
        #1;
        rst = 1'b1;
        vid = 3'(id);
    endtask

    int       vals[8];
    bit [7:0] mask;

    // Drives IDs first..NOPS-1 from vals/mask, then three non-carrier entries, then checks the strobe.
    task automatic sweep_check(input string name, input int first, input int exp0, input int exp1);
        for (int i = first; i < NOPS; i++) drive(i, mask[i], vals[i]);
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 0);
        @(negedge clk);
`ifndef MIXER_DC_BLOCK_EN
        check({name, "_ready"}, int'(r0), 1);
        check({name, "_s0"}, int'(s0), exp0);
        check({name, "_s1"}, int'(s1), exp1);
`endif
        for (int i = 3; i < NOPS; i++) drive(i, 1'b0, 0);
    endtask

    initial begin
        int cur, id, w;
        rst = 1'b1; vid = '0; alg = '0; wave = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_sample", int'(s0), 0);
        check("reset_ready", int'(r0), 0);
        check("reset_err", int'(e0), 0);

        mask = 8'hff;
        for (int i = 0; i < 8; i++) vals[i] = 100;
        sweep_check("all100", 0, 800, 200);

        mask = 8'b0010_0100;
        for (int i = 0; i < 8; i++) vals[i] = 5000;
        vals[2] = 1000; vals[5] = -300;
        sweep_check("carriers25", 0, 700, 175);

        mask = 8'hff;
        for (int i = 0; i < 8; i++) vals[i] = 32767;
        sweep_check("satpos", 0, 32767, 32767);
        for (int i = 0; i < 8; i++) vals[i] = -32768;
        sweep_check("satneg", 0, -32768, -32768);

        // Skip ID 4: error, no strobe, then a clean sweep strobes again.
        for (int i = 0; i < 8; i++) if (i != 4) drive(i, 1'b1, 100);
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 0);
        @(negedge clk);
        check("skip_nostrobe", int'(r0), 0);
        check("skip_err", int'(e0), 1);
        for (int i = 3; i < 8; i++) drive(i, 1'b0, 0);
        for (int i = 0; i < 8; i++) vals[i] = 100;
        sweep_check("after_skip", 0, 800, 200);
        check("err_sticky", int'(e0), 1);

        // Reset mid-sweep at ID 4.
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 50);
        reset_at(4);
        @(posedge clk);
        @(negedge clk);
        check("midrst_sample0", int'(s0), 0);
        check("midrst_sample1", int'(s1), 0);
        check("midrst_ready", int'(r0), 0);
        check("midrst_err", int'(e0), 0);
        for (int i = 5; i < 8; i++) drive(i, 1'b1, 50);

        // Start at ID 3 after reset: partial sweep discarded silently.
        reset_at(0);
        for (int i = 3; i < 8; i++) drive(i, 1'b1, 50);
        for (int i = 0; i < 3; i++) drive(i, 1'b1, 50);
        @(negedge clk);
        check("partial_nostrobe", int'(r0), 0);
        check("partial_noerr", int'(e0), 0);
        for (int i = 0; i < 8; i++) vals[i] = 50;
        sweep_check("first_full", 3, 400, 100);

        cur = NOPS - 1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(99);
            if (r < 1) begin
                reset_at($urandom_range(NOPS - 1));
                cur = ($urandom_range(3) == 0) ? $urandom_range(NOPS - 1) : NOPS - 1;
            end else begin
                id = (r < 4) ? $urandom_range(NOPS - 1) : (cur + 1) % NOPS;
                case ($urandom_range(3))
                    0:       w = 32767;
                    1:       w = -32768;
                    default: w = int'($urandom_range(65535)) - 32768;
                endcase
                drive(id, 1'($urandom_range(1)), w);
                cur = id;
            end
        end
        for (int i = 1; i <= 10; i++) drive((cur + i) % NOPS, 1'b0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
